hvac_actuator: RTL

- Sequential actuator stage that consumes the HVAC controller's command outputs: speed, heat, cool and idle.
- Drives the physical heater, compressor and fan with safe sequencing: fan pre-purge before engaging, post-purge after disengaging, minimum-off lockout against short-cycling, and a rate-limited fan ramp.
- Sits between the combinational temperature controller and the equipment drivers.

---
 rtl/hvac_actuator_if.sv | 39 +++
 rtl/hvac_actuator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hvac_actuator_if.sv
// hvac_actuator_if: command/status bundle between the HVAC controller and
// the actuator stage. The controller drives the command inputs (master);
// the actuator returns its registered equipment drives (slave).
// HVAC_STAT_EN adds the heat/cool start counters to the bundle.
interface hvac_actuator_if;
   logic [1:0]  speed_cmd;
   logic        heat_cmd;
   logic        cool_cmd;
   logic        idle_cmd;
   logic [1:0]  fan_level;
   logic        heater_on;
   logic        compressor_on;
   logic [2:0]  state_o;
   logic        fault;
`ifdef HVAC_STAT_EN
   logic [15:0] heat_starts;
   logic [15:0] cool_starts;

   modport master (
      output speed_cmd, heat_cmd, cool_cmd, idle_cmd,
      input  fan_level, heater_on, compressor_on, state_o, fault,
      input  heat_starts, cool_starts
   );
   modport slave (
      input  speed_cmd, heat_cmd, cool_cmd, idle_cmd,
      output fan_level, heater_on, compressor_on, state_o, fault,
      output heat_starts, cool_starts
   );
`else
   modport master (
      output speed_cmd, heat_cmd, cool_cmd, idle_cmd,
      input  fan_level, heater_on, compressor_on, state_o, fault
   );
   modport slave (
      input  speed_cmd, heat_cmd, cool_cmd, idle_cmd,
      output fan_level, heater_on, compressor_on, state_o, fault
   );
`endif
endinterface

// File: rtl/hvac_actuator.sv
// hvac_actuator: sequences heater, compressor and fan from the controller's
// speed/heat/cool/idle commands with fan pre/post purge, a minimum-off
// lockout and a rate-limited fan ramp.
// Optional macro HVAC_STAT_EN adds saturating heat/cool start counters.
//
// Command protocol: there is no handshake. The command inputs are sampled on
// every rising clk edge; a command is valid only when exactly one of
// heat/cool/idle is set, otherwise it is treated as idle and flagged on
// fault in the following cycle.
module hvac_actuator #(
   parameter int unsigned RAMP_CYCLES    = 4,
   parameter int unsigned PURGE_CYCLES   = 8,
   parameter int unsigned MIN_OFF_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic           clk,
   input  logic           rst,
   hvac_actuator_if.slave bus
);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_PREPURGE  = 3'd1,
      S_HEAT      = 3'd2,
      S_COOL      = 3'd3,
      S_POSTPURGE = 3'd4
   } state_t;

   // Timers count down to a terminal 0; loading N-1 makes the phase last
   // exactly N cycles counted from the entry edge.
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_RAMP_LAST = CNT_W'(RAMP_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_PURGE_LD  = CNT_W'(PURGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_OFF_LD    = CNT_W'(MIN_OFF_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_purge_cnt;
   logic [CNT_W-1:0] r_off_timer;
   logic [CNT_W-1:0] r_ramp_cnt;
   logic [1:0]       r_fan_level;
   logic             r_heater_on;
   logic             r_compressor_on;
   logic             r_fault;
   logic             w_valid;
   logic             w_heat_req;
   logic             w_cool_req;
   logic [1:0]       w_speed;
   logic [1:0]       w_run_target;
   logic [1:0]       w_target;

   // Exactly one of three: odd parity and not all three set.
   assign w_valid    = (bus.heat_cmd ^ bus.cool_cmd ^ bus.idle_cmd) &
                       ~(bus.heat_cmd & bus.cool_cmd & bus.idle_cmd);
   assign w_heat_req = w_valid & bus.heat_cmd;
   assign w_cool_req = w_valid & bus.cool_cmd;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_OFF;
      else     r_state <= w_next;
   end

   // Next-state logic; HEAT and COOL always pass through POSTPURGE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_OFF: begin
            if ((w_heat_req | w_cool_req) && r_off_timer == '0) w_next = S_PREPURGE;
         end
         S_PREPURGE: begin
            if (!(w_heat_req | w_cool_req))                  w_next = S_OFF;
            else if (r_purge_cnt == '0 && r_fan_level != 2'd0) w_next = w_heat_req ? S_HEAT : S_COOL;
         end
         S_HEAT:      if (!w_heat_req)        w_next = S_POSTPURGE;
         S_COOL:      if (!w_cool_req)        w_next = S_POSTPURGE;
         S_POSTPURGE: if (r_purge_cnt == '0)  w_next = S_OFF;
         default:                             w_next = S_OFF;
      endcase
   end

   // Purge timer: reloaded on entry to either purge state, otherwise runs down.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_purge_cnt <= '0;
      else if (w_next != r_state && (w_next == S_PREPURGE || w_next == S_POSTPURGE))
         r_purge_cnt <= C_PURGE_LD;
      else if (r_purge_cnt != '0)
         r_purge_cnt <= r_purge_cnt - C_ONE;
   end

   // Short-cycle lockout: armed when equipment disengages, runs in all states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_off_timer <= '0;
      else if (w_next == S_POSTPURGE && r_state != S_POSTPURGE)
         r_off_timer <= C_OFF_LD;
      else if (r_off_timer != '0)
         r_off_timer <= r_off_timer - C_ONE;
   end

   // Fan target: invalid commands ask for speed 0, running states force >= 1.
   always_comb begin
      w_speed      = w_valid ? bus.speed_cmd : 2'd0;
      w_run_target = (w_speed == 2'd0) ? 2'd1 : w_speed;
      case (r_state)
         S_OFF:       w_target = 2'd0;
         S_POSTPURGE: w_target = 2'd1;
         default:     w_target = w_run_target;
      endcase
   end

   // Fan ramp: one step per RAMP_CYCLES; the count survives target changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ramp_cnt  <= '0;
         r_fan_level <= 2'd0;
      end else if (r_fan_level == w_target) begin
         r_ramp_cnt  <= '0;
      end else if (r_ramp_cnt == C_RAMP_LAST) begin
         r_ramp_cnt  <= '0;
         r_fan_level <= (r_fan_level < w_target) ? r_fan_level + 2'd1 : r_fan_level - 2'd1;
      end else begin
         r_ramp_cnt  <= r_ramp_cnt + C_ONE;
      end
   end

   // Equipment enables follow the state being entered so they line up with state_o.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_heater_on     <= 1'b0;
         r_compressor_on <= 1'b0;
         r_fault         <= 1'b0;
      end else begin
         r_heater_on     <= (w_next == S_HEAT);
         r_compressor_on <= (w_next == S_COOL);
         r_fault         <= ~w_valid;
      end
   end

   assign bus.fan_level     = r_fan_level;
   assign bus.heater_on     = r_heater_on;
   assign bus.compressor_on = r_compressor_on;
   assign bus.state_o       = r_state;
   assign bus.fault         = r_fault;

`ifdef HVAC_STAT_EN
   logic [15:0] r_heat_starts;
   logic [15:0] r_cool_starts;

   // Saturating counts of entries into HEAT and COOL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_heat_starts <= '0;
         r_cool_starts <= '0;
      end else begin
         if (w_next == S_HEAT && r_state != S_HEAT && r_heat_starts != 16'hFFFF)
            r_heat_starts <= r_heat_starts + 16'd1;
         if (w_next == S_COOL && r_state != S_COOL && r_cool_starts != 16'hFFFF)
            r_cool_starts <= r_cool_starts + 16'd1;
      end
   end

   assign bus.heat_starts = r_heat_starts;
   assign bus.cool_starts = r_cool_starts;
`endif

endmodule
